// File: rtl/mul_issuer_if.sv
// Producer, multiplier and consumer signals around mul_issuer.
// slave is the issuer's view of the bundle; master is the surrounding environment.
interface mul_issuer_if;
  logic [7:0]  op_a;
  logic [7:0]  op_b;
  logic        op_vld;
  logic        op_rdy;
  logic [7:0]  mul_a;
  logic [7:0]  mul_b;
  logic        mul_vld;
  logic [15:0] mul_res;
  logic        mul_rdy;
  logic [15:0] out_res;
  logic [7:0]  out_a;
  logic [7:0]  out_b;
  logic        out_vld;
  logic        out_rdy;
  logic        err;
  logic [15:0] done_cnt;

  modport master (
    output op_a, op_b, op_vld, mul_res, mul_rdy, out_rdy,
    input  op_rdy, mul_a, mul_b, mul_vld, out_res, out_a, out_b, out_vld, err, done_cnt
  );

  modport slave (
    input  op_a, op_b, op_vld, mul_res, mul_rdy, out_rdy,
    output op_rdy, mul_a, mul_b, mul_vld, out_res, out_a, out_b, out_vld, err, done_cnt
  );
endinterface

// File: rtl/mul_issuer.sv
// Queues operand pairs and issues them one at a time to a sequential 8x8 multiplier.
// Push-to-out_vld is 11 cycles with an 8-step multiplier; op_rdy drops when the queue is full.
module mul_issuer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  mul_issuer_if.slave    io_bus
);

  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int WCW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t          r_state;
  logic [7:0]      r_mul_a;
  logic [7:0]      r_mul_b;
  logic            r_mul_vld;
  logic [15:0]     r_out_res;
  logic [7:0]      r_out_a;
  logic [7:0]      r_out_b;
  logic            r_out_vld;
  logic            r_err;
  logic [15:0]     r_done_cnt;
  logic [WCW-1:0]  r_wait_cnt;

  logic [15:0]     r_mem [DEPTH];
  logic [AW:0]     r_wr_ptr;
  logic [AW:0]     r_rd_ptr;

  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  logic [15:0]     w_head;
  logic [WCW-1:0]  w_wait_nxt;

  // Extra pointer bit tells full from empty when the index bits match.
  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  assign w_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_head     = r_mem[r_rd_ptr[AW-1:0]];
  assign w_push     = io_bus.op_vld && io_bus.op_rdy;
  assign w_pop      = (r_state == S_IDLE) && !w_empty;
  assign w_wait_nxt = r_wait_cnt + WCW'(1);

  assign io_bus.op_rdy = rst_n && !w_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= {io_bus.op_a, io_bus.op_b};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_mul_a    <= '0;
      r_mul_b    <= '0;
      r_mul_vld  <= 1'b0;
      r_out_res  <= '0;
      r_out_a    <= '0;
      r_out_b    <= '0;
      r_out_vld  <= 1'b0;
      r_err      <= 1'b0;
      r_done_cnt <= '0;
      r_wait_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            r_mul_a   <= w_head[15:8];
            r_mul_b   <= w_head[7:0];
            r_mul_vld <= 1'b1;
            r_state   <= S_ISSUE;
          end
        end
        // mul_rdy is still high from the previous product here, so it is not looked at.
        S_ISSUE: begin
          r_mul_vld  <= 1'b0;
          r_wait_cnt <= '0;
          r_state    <= S_WAIT;
        end
        S_WAIT: begin
          if (io_bus.mul_rdy) begin
            r_out_res <= io_bus.mul_res;
            r_out_a   <= r_mul_a;
            r_out_b   <= r_mul_b;
            r_out_vld <= 1'b1;
            r_state   <= S_HOLD;
          end else if (w_wait_nxt == WCW'(TIMEOUT)) begin
            r_err   <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_wait_cnt <= w_wait_nxt;
          end
        end
        S_HOLD: begin
          if (io_bus.out_rdy) begin
            r_out_vld  <= 1'b0;
            r_done_cnt <= r_done_cnt + 16'd1;
            r_state    <= S_IDLE;
          end
        end
        default: begin
          r_mul_vld <= 1'b0;
          r_out_vld <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  assign io_bus.mul_a    = r_mul_a;
  assign io_bus.mul_b    = r_mul_b;
  assign io_bus.mul_vld  = r_mul_vld;
  assign io_bus.out_res  = r_out_res;
  assign io_bus.out_a    = r_out_a;
  assign io_bus.out_b    = r_out_b;
  assign io_bus.out_vld  = r_out_vld;
  assign io_bus.err      = r_err;
  assign io_bus.done_cnt = r_done_cnt;

endmodule

// File: tb/tb_mul_issuer.sv
// Bench for mul_issuer: 8-step multiplier model, in-order product scoreboard,
// directed latency/fill/timeout/reset scenarios and a randomized traffic phase.
module tb_mul_issuer;

  logic clk;
  logic rst_n;

  mul_issuer_if bus();

  mul_issuer #(.DEPTH(4), .TIMEOUT(16)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus)
  );

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
  } op_t;

  op_t  exp_q[$];
  int   n_checks = 0;
  int   n_errs   = 0;
  int   n_done   = 0;
  logic m_stall  = 1'b0;

  logic       m_start;
  logic [7:0] m_a, m_b, ma, mb;
  int         mcnt;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Sequential multiplier: starts on a mul_vld edge, product ready 8 edges later.
  initial begin
    bus.mul_rdy = 1'b1;
    bus.mul_res = 16'h0;
    mcnt = 0;
    forever begin
      @(negedge clk);
      m_start = bus.mul_vld;
      m_a     = bus.mul_a;
      m_b     = bus.mul_b;
      @(posedge clk);
      #1;
      if (!rst_n) begin
        mcnt = 0;
        bus.mul_rdy = 1'b1;
      end else if (m_start) begin
        bus.mul_rdy = 1'b0;
        bus.mul_res = 16'($urandom);
        ma = m_a;
        mb = m_b;
        mcnt = 8;
      end else if (mcnt != 0) begin
        mcnt--;
        if (mcnt == 0 && !m_stall) begin
          bus.mul_rdy = 1'b1;
          bus.mul_res = 16'(ma) * 16'(mb);
        end
      end
    end
  end

  // Scoreboard: operands in push order, product computed from the operands.
  initial begin
    op_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.out_vld) begin
          if (exp_q.size() == 0) begin
            chk_eq("out_vld_unexpected", 32'(bus.out_vld), 32'(0));
          end else begin
            e = exp_q[0];
            chk_eq("out_a", 32'(bus.out_a), 32'(e.a));
            chk_eq("out_b", 32'(bus.out_b), 32'(e.b));
            chk_eq("out_res", 32'(bus.out_res), 32'(16'(e.a) * 16'(e.b)));
            if (bus.out_rdy) begin
              void'(exp_q.pop_front());
              n_done++;
            end
          end
        end
        if (bus.op_vld && bus.op_rdy) begin
          exp_q.push_back({bus.op_a, bus.op_b});
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic push_one(input logic [7:0] a, input logic [7:0] b);
    bit ok;
    @(posedge clk);
    #1;
    bus.op_a   = a;
    bus.op_b   = b;
    bus.op_vld = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (bus.op_rdy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk_eq("push_rdy_timeout", 32'(bus.op_rdy), 32'(1));
    @(posedge clk);
    #1;
    bus.op_vld = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    for (int t = 0; t < budget; t++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0 && !bus.out_vld) break;
    end
    chk_eq("drain", 32'(exp_q.size()), 32'(0));
  endtask

  task automatic chk_all_zero(input string tag);
    chk_eq({tag, "_op_rdy"},   32'(bus.op_rdy),   32'(0));
    chk_eq({tag, "_mul_vld"},  32'(bus.mul_vld),  32'(0));
    chk_eq({tag, "_out_vld"},  32'(bus.out_vld),  32'(0));
    chk_eq({tag, "_err"},      32'(bus.err),      32'(0));
    chk_eq({tag, "_mul_a"},    32'(bus.mul_a),    32'(0));
    chk_eq({tag, "_mul_b"},    32'(bus.mul_b),    32'(0));
    chk_eq({tag, "_out_res"},  32'(bus.out_res),  32'(0));
    chk_eq({tag, "_out_a"},    32'(bus.out_a),    32'(0));
    chk_eq({tag, "_out_b"},    32'(bus.out_b),    32'(0));
    chk_eq({tag, "_done_cnt"}, 32'(bus.done_cnt), 32'(0));
  endtask

  function automatic logic [7:0] rnd_op();
    case ($urandom_range(0, 5))
      0:       return 8'h00;
      1:       return 8'hFF;
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    int   base;
    int   acc_n;
    logic acc;

    rst_n       = 1'b1;
    bus.op_vld  = 1'b0;
    bus.op_a    = 8'h0;
    bus.op_b    = 8'h0;
    bus.out_rdy = 1'b0;

    #2 rst_n = 1'b0;
    #1 chk_all_zero("rst");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk_eq("rdy_after_rst", 32'(bus.op_rdy), 32'(1));
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk_eq("idle_out_vld", 32'(bus.out_vld), 32'(0));
      chk_eq("idle_mul_vld", 32'(bus.mul_vld), 32'(0));
    end

    // Single op latency; mul_rdy is still high from reset during ISSUE.
    bus.out_rdy = 1'b1;
    push_one(8'h0D, 8'h0B);
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      chk_eq($sformatf("lat_mul_vld_k%0d", k), 32'(bus.mul_vld), 32'(k == 1));
      chk_eq($sformatf("lat_out_vld_k%0d", k), 32'(bus.out_vld), 32'(k == 11));
    end
    wait_drain(50);
    chk_eq("res_0d0b", 32'(bus.out_res), 32'(16'h008F));
    chk_eq("done_one", 32'(bus.done_cnt), 32'(1));

    push_one(8'hFF, 8'hFF);
    push_one(8'h00, 8'h7F);
    wait_drain(100);
    chk_eq("res_last_zero", 32'(bus.out_res), 32'(0));
    chk_eq("done_three", 32'(bus.done_cnt), 32'(n_done));

    // Fill: first op is popped, four more fill the queue, sixth is refused.
    bus.out_rdy = 1'b0;
    base = n_done;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk);
      #1;
      bus.op_a   = 8'(i * 16 + 3);
      bus.op_b   = 8'(i + 7);
      bus.op_vld = 1'b1;
      @(negedge clk);
      chk_eq($sformatf("fill_rdy_%0d", i), 32'(bus.op_rdy), 32'(i < 6));
    end
    @(posedge clk);
    #1 bus.op_vld = 1'b0;
    repeat (20) @(negedge clk);
    chk_eq("fill_hold_vld", 32'(bus.out_vld), 32'(1));
    chk_eq("fill_accepted", 32'(exp_q.size()), 32'(5));
    @(posedge clk);
    #1 bus.out_rdy = 1'b1;
    wait_drain(200);
    chk_eq("fill_done", 32'(bus.done_cnt), 32'(base + 5));

    // Multiplier never answers: 16 WAIT cycles then err, op dropped.
    m_stall = 1'b1;
    push_one(8'h12, 8'h34);
    for (int k = 0; k < 21; k++) begin
      @(negedge clk);
      chk_eq($sformatf("to_err_k%0d", k), 32'(bus.err), 32'(k >= 18));
      chk_eq("to_out_vld", 32'(bus.out_vld), 32'(0));
    end
    #1;
    void'(exp_q.pop_front());
    m_stall = 1'b0;
    push_one(8'h05, 8'h07);
    wait_drain(100);
    chk_eq("err_sticky", 32'(bus.err), 32'(1));
    chk_eq("done_after_to", 32'(bus.done_cnt), 32'(n_done));

    // Reset while in WAIT with two ops still queued.
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      bus.op_a   = 8'(8'h21 + i);
      bus.op_b   = 8'(8'h43 + i);
      bus.op_vld = 1'b1;
      @(posedge clk);
      #1;
    end
    bus.op_vld = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 chk_all_zero("midrst");
    exp_q.delete();
    n_done = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk_eq("rdy_after_midrst", 32'(bus.op_rdy), 32'(1));
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk_eq("post_rst_out_vld", 32'(bus.out_vld), 32'(0));
      chk_eq("post_rst_mul_vld", 32'(bus.mul_vld), 32'(0));
    end

    // Random traffic with random consumer backpressure.
    acc_n = 0;
    for (int c = 0; c < 4000 && acc_n < 40; c++) begin
      @(negedge clk);
      acc = bus.op_vld && bus.op_rdy;
      if (acc) acc_n++;
      @(posedge clk);
      #1;
      bus.out_rdy = ($urandom_range(0, 3) != 0);
      if (acc || !bus.op_vld) begin
        if (acc_n < 40 && $urandom_range(0, 1) == 0) begin
          bus.op_a   = rnd_op();
          bus.op_b   = rnd_op();
          bus.op_vld = 1'b1;
        end else begin
          bus.op_vld = 1'b0;
        end
      end
    end
    bus.op_vld = 1'b0;
    chk_eq("rand_accepted", 32'(acc_n), 32'(40));
    bus.out_rdy = 1'b1;
    wait_drain(1000);
    chk_eq("rand_done", 32'(bus.done_cnt), 32'(n_done));
    chk_eq("rand_err_clear", 32'(bus.err), 32'(0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule

// File: doc/mul_issuer.md
MUL_ISSUER -- requirements
Module: mul_issuer

Interface
REQ-001 Parameter: DEPTH, default 4, operand FIFO entries (power of two, 2..16).
REQ-002 Parameter: TIMEOUT, default 16, maximum WAIT cycles before a result is abandoned.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 op_a, op_b  input  8 each  operand pair from the producer.
REQ-006 op_vld  input  1  operand pair valid.
REQ-007 op_rdy  output  1  FIFO can accept; a push occurs on an edge where op_vld and op_rdy are both high.
REQ-008 mul_a, mul_b  output  8 each  operands driven to the 8x8 sequential multiplier.
REQ-009 mul_vld  output  1  one-cycle start pulse to the multiplier.
REQ-010 mul_res  input  16  multiplier product.
REQ-011 mul_rdy  input  1  multiplier done level; high after multiplier reset and until the next start.
REQ-012 out_res  output  16  captured product.
REQ-013 out_a, out_b  output  8 each  operands belonging to out_res.
REQ-014 out_vld, out_rdy  output/input  1 each  result handshake; transfer on an edge where both are high.
REQ-015 err  output  1  sticky timeout flag.
REQ-016 done_cnt  output  16  count of delivered results.

Function
REQ-017 The FIFO shall be in-order with no bypass; op_rdy shall equal not-full, and shall be 0 while rst_n is low.
REQ-018 FSM states shall be IDLE, ISSUE, WAIT and HOLD.
REQ-019 IDLE: FIFO non-empty -> pop head into mul_a/mul_b, go to ISSUE; otherwise stay.
REQ-020 ISSUE: mul_vld=1 for exactly this cycle; mul_rdy shall be ignored (stale); go to WAIT and clear the wait counter.
REQ-021 mul_vld shall be 0 in every state except ISSUE.
REQ-022 WAIT: mul_rdy=1 -> capture mul_res into out_res and mul_a/mul_b into out_a/out_b, go to HOLD.
REQ-023 WAIT: otherwise increment the wait counter; on reaching TIMEOUT -> set err, discard the operation, go to IDLE.
REQ-024 HOLD: out_vld=1; while out_rdy=0, out_res, out_a and out_b shall be held stable.
REQ-025 HOLD: out_rdy=1 -> done_cnt+1 (wraps 0xFFFF->0), go to IDLE.
REQ-026 out_vld shall be 0 in every state except HOLD.
REQ-027 A push and a pop on the same edge shall both take effect; occupancy is unchanged.
REQ-028 Latency: push on edge E0 into an empty FIFO while in IDLE -> mul_vld high during cycle E1..E2 -> out_vld high from E11, given an 8-step multiplier.
REQ-029 Only one operation shall be outstanding at the multiplier; throughput is at most one result per 11 cycles.
REQ-030 mul_a/mul_b shall hold their values until the next pop.
REQ-031 err shall clear only on reset.

Reset
REQ-032 rst_n low shall immediately force:
  - state to IDLE and the FIFO to empty;
  - mul_vld, out_vld, op_rdy and err to 0;
  - mul_a, mul_b, out_res, out_a, out_b, done_cnt and the wait counter to 0.
REQ-033 Reset mid-operation (any state) shall discard FIFO contents and any in-flight result without emitting out_vld.
REQ-034 After rst_n rises, op_rdy=1 on the first cycle; mul_rdy=1 at that time shall not produce out_vld.

Verification
REQ-035 Single op 0x0D*0x0B, out_rdy=1 -> one mul_vld pulse at E1; out_vld at E11, out_res=0x008F, done_cnt=1.
REQ-036 Operands 0xFF*0xFF, then 0x00*0x7F -> out_res=0xFE01 then 0x0000, in order.
REQ-037 Push 6 ops back-to-back with out_rdy=0 -> first op popped; 5 accepted; op_rdy=0 on the 6th push attempt.
REQ-037 (cont.) Then release out_rdy -> all results delivered in push order; done_cnt=5.
REQ-038 Bench multiplier holds mul_rdy=0 -> err=1 after 16 WAIT cycles, state IDLE, no out_vld.
REQ-038 (cont.) Next op with a normal multiplier completes; err stays 1.
REQ-039 rst_n pulsed low in WAIT with 2 ops queued -> all outputs 0, FIFO empty.
REQ-039 (cont.) No out_vld after release, even with mul_rdy=1.
REQ-040 mul_rdy stuck high during ISSUE from a previous result -> no capture in ISSUE; capture occurs only after mul_rdy falls and rises again in WAIT.
